// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: instruction width, NOP encoding and a
// constant-evaluable ceiling log2 used to size address and pointer fields.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam int WORD_BYTES = INSTR_W / 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: one synchronous write port and one registered read
// port, read-before-write on a same-address collision. No reset so it maps to block RAM.
import cpu_pkg::*;

module instr_mem_array #(
  parameter int DATA_W = INSTR_W,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write and read share the edge; the read samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_sync.sv
// Instruction memory with a one-cycle byte-addressed fetch port that flags
// misaligned/out-of-range PCs, and an auto-incrementing program-load port.
import cpu_pkg::*;

module instr_mem_sync #(
  parameter int                DATA_W    = INSTR_W,
  parameter int                DEPTH     = 256,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  input  logic                     stall,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_fault,
  input  logic                     prog_start,
  input  logic                     prog_we,
  input  logic [DATA_W-1:0]        prog_data,
  output logic [clog2(DEPTH):0]    prog_ptr,
  output logic                     prog_full
);

  localparam int IDX_W = clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = clog2(BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [PTR_W-1:0]  DEPTH_P  = PTR_W'(DEPTH);

  logic [ADDR_W-1:0] offset_s;
  logic [ADDR_W-1:0] index_s;
  logic              misaligned_s;
  logic              range_err_s;
  logic              fault_s;
  logic              accept_s;
  logic              re_s;
  logic              we_s;
  logic [PTR_W-1:0]  ptr_nxt_s;
  logic [DATA_W-1:0] ram_q_s;

  logic              valid_r;
  logic              fault_r;
  logic              data_ok_r;
  logic [PTR_W-1:0]  ptr_r;
  logic              full_r;

  // Fetch address decode: word index, alignment and range checks in ADDR_W bits.
  always_comb begin
    offset_s     = fetch_addr - BASE_ADDR;
    index_s      = offset_s >> OFF_W;
    misaligned_s = ((fetch_addr & OFF_MASK) != {ADDR_W{1'b0}});
    range_err_s  = (fetch_addr < BASE_ADDR) || (index_s >= DEPTH_A);
    fault_s      = misaligned_s || range_err_s;
    accept_s     = fetch_req && !stall;
    re_s         = accept_s && !fault_s;
  end

  // Load pointer: a start pulse wins over a write; writes stop once full.
  always_comb begin
    we_s = prog_we && !prog_start && !full_r && !rst;
    if (prog_start) begin
      ptr_nxt_s = {PTR_W{1'b0}};
    end else if (we_s) begin
      ptr_nxt_s = ptr_r + PTR_W'(1);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we_s),
    .waddr (ptr_r[IDX_W-1:0]),
    .wdata (prog_data),
    .re    (re_s),
    .raddr (index_s[IDX_W-1:0]),
    .rdata (ram_q_s)
  );

  // Response flags and load pointer; stall freezes the whole response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r   <= 1'b0;
      fault_r   <= 1'b0;
      data_ok_r <= 1'b0;
      ptr_r     <= {PTR_W{1'b0}};
      full_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        valid_r   <= 1'b1;
        fault_r   <= fault_s;
        data_ok_r <= !fault_s;
      end else if (!stall) begin
        valid_r   <= 1'b0;
      end else begin
        valid_r   <= valid_r;
      end
      ptr_r  <= ptr_nxt_s;
      full_r <= (ptr_nxt_s == DEPTH_P);
    end
  end

  // The RAM holds its last read, so data_ok_r alone decides NOP vs. word.
  assign rsp_data  = data_ok_r ? ram_q_s : DATA_W'(NOP_INSTR);
  assign rsp_valid = valid_r;
  assign rsp_fault = fault_r;
  assign prog_ptr  = ptr_r;
  assign prog_full = full_r;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync: a behavioural model predicts each
// cycle's response and load pointer, which are compared after the edge.
module tb_instr_mem_sync;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'd0;
  logic        stall = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        prog_start = 1'b0;
  logic        prog_we = 1'b0;
  logic [31:0] prog_data = 32'd0;
  logic [8:0]  prog_ptr;
  logic        prog_full;

  instr_mem_sync #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_fault  (rsp_fault),
    .prog_start (prog_start),
    .prog_we    (prog_we),
    .prog_data  (prog_data),
    .prog_ptr   (prog_ptr),
    .prog_full  (prog_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        chk_data;
    logic        fault;
    logic [8:0]  ptr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic        model_known [DEPTH];
  logic        m_valid = 1'b0;
  logic [31:0] m_data = 32'd0;
  logic        m_known = 1'b1;
  logic        m_fault = 1'b0;
  logic [8:0]  m_ptr = 9'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input logic req, input logic [31:0] addr, input logic stl,
                      input logic ps, input logic pwe, input logic [31:0] pd);
    exp_t e;
    logic [31:0] idx;
    fetch_req  = req;
    fetch_addr = addr;
    stall      = stl;
    prog_start = ps;
    prog_we    = pwe;
    prog_data  = pd;
    if (!stl) begin
      if (req) begin
        idx     = addr >> 2;
        m_valid = 1'b1;
        m_fault = (addr[1:0] != 2'b00) || (idx >= 32'(DEPTH));
        if (m_fault) begin
          m_data  = 32'd0;
          m_known = 1'b1;
        end else begin
          m_data  = model_mem[idx[7:0]];
          m_known = model_known[idx[7:0]];
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    if (ps) begin
      m_ptr = 9'd0;
    end else if (pwe && (m_ptr < 9'(DEPTH))) begin
      model_mem[m_ptr[7:0]]   = pd;
      model_known[m_ptr[7:0]] = 1'b1;
      m_ptr = m_ptr + 9'd1;
    end
    e.valid = m_valid; e.data = m_data; e.chk_data = m_known;
    e.fault = m_fault; e.ptr = m_ptr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("rsp_valid", 32'(rsp_valid), 32'(e.valid));
    check_eq("rsp_fault", 32'(rsp_fault), 32'(e.fault));
    if (e.chk_data) check_eq("rsp_data", rsp_data, e.data);
    check_eq("prog_ptr", 32'(prog_ptr), 32'(e.ptr));
    check_eq("prog_full", 32'(prog_full), 32'(e.ptr == 9'(DEPTH)));
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h8D88_0000; prog[1] = 32'h8D89_0004;
    prog[2] = 32'h0128_5020; prog[3] = 32'hAD8A_0008;
    for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;

    #2 rst = 1'b1;
    #2;
    check_eq("reset_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_data", rsp_data, 32'd0);
    check_eq("reset_fault", 32'(rsp_fault), 32'd0);
    check_eq("reset_ptr", 32'(prog_ptr), 32'd0);
    check_eq("reset_full", 32'(prog_full), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Load then fetch
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, prog[i]);
    check_eq("t1_ptr4", 32'(prog_ptr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'd0);
      check_eq("t1_word", rsp_data, prog[i]);
    end
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Faults
    step(1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("t2_misalign", 32'(rsp_fault), 32'd1);
    step(1'b1, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("t2_range_data", rsp_data, 32'd0);
    step(1'b1, 32'h0000_03FC, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("t2_last_ok", 32'(rsp_fault), 32'd0);
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'd0);

    // Stall hold
    step(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 32'd0);
      check_eq("t3_hold", rsp_data, 32'h8D89_0004);
    end
    step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("t3_release", rsp_data, 32'h0128_5020);
    step(1'b0, 32'h8, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 32'h8, 1'b0, 1'b0, 1'b0, 32'd0);

    // Read-before-write collision
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    check_eq("t4_old", rsp_data, 32'h8D88_0000);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("t4_new", rsp_data, 32'hFFFF_FFFF);

    // Fill limits
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < DEPTH + 2; i++)
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hA000_0000 + 32'(i));
    check_eq("t5_full", 32'(prog_full), 32'd1);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("t5_word0", rsp_data, 32'hA000_0000);
    step(1'b1, 32'h3FC, 1'b0, 1'b1, 1'b1, 32'h1234_5678);
    check_eq("t5_start_ptr", 32'(prog_ptr), 32'd0);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("t5_nowrite", rsp_data, 32'hA000_0000);

    // Async reset mid fetch and load
    step(1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 32'hA000_0000);
    step(1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 32'hA000_0001);
    fetch_req = 1'b1; fetch_addr = 32'h8; prog_we = 1'b1; prog_data = 32'hDEAD_BEEF;
    #2 rst = 1'b1;
    #1;
    check_eq("t6_valid", 32'(rsp_valid), 32'd0);
    check_eq("t6_data", rsp_data, 32'd0);
    check_eq("t6_fault", 32'(rsp_fault), 32'd0);
    check_eq("t6_ptr", 32'(prog_ptr), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t6_hold_ptr", 32'(prog_ptr), 32'd0);
    rst = 1'b0;
    m_valid = 1'b0; m_data = 32'd0; m_fault = 1'b0; m_known = 1'b1; m_ptr = 9'd0;
    step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("t6_no_write", rsp_data, 32'hA000_0002);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
Parametrised instruction memory for the single-cycle/multi-cycle CPU datapath.
- Replaces the fixed 32-entry combinational ROM with a DEPTH-word RAM.
- Byte-addressed fetch with a registered one-cycle read.
- Auto-incrementing program-load port, so test programs are loaded at run time instead of hard-coded.
- Reports misaligned and out-of-range fetches instead of returning undefined data.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 256, number of instruction words; must be a power of two, at least 2.
- ADDR_W, 32, width of the byte address from the PC.
- BASE_ADDR, 0, byte address of word 0; must be DATA_W/8 aligned.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- fetch_req, in, 1, fetch request for this cycle.
- fetch_addr, in, ADDR_W, byte address (PC).
- stall, in, 1, hold the current response; no new fetch is accepted.
- rsp_valid, out, 1, rsp_data/rsp_fault are valid.
- rsp_data, out, DATA_W, fetched instruction; NOP (all zeros) on fault.
- rsp_fault, out, 1, fetch was misaligned or out of range.
- prog_start, in, 1, pulse; resets the load pointer to word 0.
- prog_we, in, 1, write prog_data at the load pointer, then increment the pointer.
- prog_data, in, DATA_W, word to load.
- prog_ptr, out, clog2(DEPTH)+1, current load pointer; equals DEPTH when full.
- prog_full, out, 1, prog_ptr == DEPTH.

Behaviour:
Reset (asynchronous, active-high):
- rsp_valid=0, rsp_data=0, rsp_fault=0, prog_ptr=0, prog_full=0.
- Memory contents are not reset and are undefined until loaded.
- Reset asserted mid-load or mid-fetch aborts immediately; the outputs above are forced the same cycle.

Fetch path:
- Latency is 1 cycle: fetch_req=1 and stall=0 at edge N gives the result on rsp_* after edge N.
- Word index = (fetch_addr - BASE_ADDR) >> log2(DATA_W/8).
- Misaligned: the low log2(DATA_W/8) bits are nonzero. Result: rsp_fault=1, rsp_data=0.
- Out of range: fetch_addr < BASE_ADDR, or word index >= DEPTH. Result: rsp_fault=1, rsp_data=0.
- Otherwise rsp_fault=0 and rsp_data = mem[index].
- stall=1: rsp_valid, rsp_data and rsp_fault all hold their values; fetch_req is ignored.
- fetch_req=0 and stall=0: rsp_valid<=0. rsp_data and rsp_fault hold their last values.

Load path:
- prog_start=1: prog_ptr<=0. Takes priority over a prog_we in the same cycle; that write is dropped.
- prog_we=1 with prog_ptr<DEPTH: mem[prog_ptr]<=prog_data, prog_ptr<=prog_ptr+1.
- prog_we=1 with prog_full=1: write ignored, pointer saturates at DEPTH and never wraps.

Simultaneous events:
- A fetch and a load to the same word in the same cycle is read-before-write: the fetch returns the old contents.
- A fetch on the following cycle returns the new word.
- Fetch and load are otherwise independent and may proceed every cycle.

Arithmetic:
- Subtraction and comparison are done in ADDR_W bits, unsigned.
- prog_ptr has one extra bit so the full condition is representable.

Decomposition:
Shared package cpu_pkg:
- INSTR_W=32
- NOP_INSTR=32'h0000_0000
- WORD_BYTES=INSTR_W/8
- Function clog2.

Sub-module instr_mem_array (DEPTH x DATA_W):
- One synchronous write port and one synchronous read port, read-before-write.
- No reset; infers block RAM.
- Top level holds the address decode/fault logic, response registers, stall hold and load pointer.

Test Plan:
1. Load then fetch: prog_start, then load 0x8D880000, 0x8D890004, 0x01285020, 0xAD8A0008. Fetch addr 0x0,0x4,0x8,0xC on consecutive cycles -> rsp_data equals those words one cycle later, rsp_valid=1, rsp_fault=0; prog_ptr=4.
2. Fault cases with DEPTH=256: fetch 0x2 -> rsp_fault=1, rsp_data=0. Fetch 0x400 -> rsp_fault=1, rsp_data=0. Fetch 0x3FC -> rsp_fault=0.
3. Stall: fetch 0x4, then stall=1 for 3 cycles while fetch_addr=0x8 -> rsp_data stays 0x8D890004, rsp_valid stays 1. Release stall -> 0x01285020 next cycle.
4. Same-cycle collision: fetch 0x0 together with a write of 0xFFFFFFFF to word 0 -> response shows the old 0x8D880000. Next fetch of 0x0 -> 0xFFFFFFFF.
5. Fill limits: write DEPTH+2 words -> prog_full=1, prog_ptr=DEPTH, word 0 unchanged. prog_start with prog_we in the same cycle -> prog_ptr=0, no write.
6. Async reset: assert rst between clock edges during an active fetch and load -> rsp_valid=0, rsp_data=0, rsp_fault=0, prog_ptr=0 immediately, without waiting for a clock edge.
